// File: rtl/layer_header_scanner.sv
// rtl/layer_header_scanner.sv - per-scanline layer header scan with visible-layer output FIFO
// Optional LAYER_HDR_CLIP_EN: clip pushed width to SCREEN_W and drop layers starting off-screen.
module layer_header_scanner #(
  parameter int NUM_LAYERS = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 640
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  line_y,
  output logic [4:0]   read_layer,
  input  logic [127:0] layer_info,
  output logic         busy,
  output logic         done,
  output logic [5:0]   hit_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_layer,
  output logic [127:0] out_header
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [4:0]    LAST_IDX = 5'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CHECK, S_PUSH, S_FIN} state_t;

  state_t         r_state;
  logic [15:0]    r_line;
  logic [4:0]     r_idx;
  logic [5:0]     r_cnt;
  logic [127:0]   r_held;

  logic [132:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           w_enable;
  logic [15:0]    w_y_start;
  logic [15:0]    w_height;
  logic [16:0]    w_dy;
  logic           w_in_rows;
  logic           w_visible;
  logic [127:0]   w_hdr;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic [132:0]   w_push_data;
  logic           w_advance;
  logic [5:0]     w_cnt_next;

  assign w_enable  = layer_info[0];
  assign w_y_start = layer_info[47:32];
  assign w_height  = layer_info[79:64];

  // 17-bit compare so a layer running past line 0xFFFF never wraps back to the top
  assign w_dy      = {1'b0, r_line} - {1'b0, w_y_start};
  assign w_in_rows = ({1'b0, r_line} >= {1'b0, w_y_start}) && (w_dy < {1'b0, w_height});

`ifdef LAYER_HDR_CLIP_EN
  logic [15:0] w_x_start;
  logic [15:0] w_width;
  logic [16:0] w_room;
  logic        w_x_ok;
  logic [15:0] w_clip_width;

  assign w_x_start    = layer_info[31:16];
  assign w_width      = layer_info[63:48];
  assign w_x_ok       = {1'b0, w_x_start} < 17'(SCREEN_W);
  assign w_room       = 17'(SCREEN_W) - {1'b0, w_x_start};
  assign w_clip_width = ({1'b0, w_width} > w_room) ? w_room[15:0] : w_width;
  assign w_hdr        = {layer_info[127:64], w_clip_width, layer_info[47:0]};
  assign w_visible    = w_enable && w_in_rows && w_x_ok;
`else
  assign w_hdr        = layer_info;
  assign w_visible    = w_enable && w_in_rows;
`endif

  // Fullness uses the registered count: a same-cycle pop frees a slot only next cycle
  assign w_full    = (r_count == DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_layer  = r_mem[r_rd_ptr][132:128];
  assign out_header = r_mem[r_rd_ptr][127:0];

  always_comb begin
    w_push      = 1'b0;
    w_push_data = {r_idx, w_hdr};
    w_advance   = 1'b0;
    if (r_state == S_CHECK) begin
      w_push    = w_visible && !w_full;
      w_advance = !w_visible || !w_full;
    end else if (r_state == S_PUSH) begin
      w_push      = !w_full;
      w_advance   = !w_full;
      w_push_data = {r_idx, r_held};
    end
  end

  assign w_cnt_next = r_cnt + {5'd0, w_push};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_held     <= '0;
      read_layer <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_count  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_line     <= line_y;
            r_idx      <= '0;
            r_cnt      <= '0;
            read_layer <= '0;
            busy       <= 1'b1;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: r_state <= S_CHECK;
        S_CHECK, S_PUSH: begin
          r_cnt <= w_cnt_next;
          if (w_advance) begin
            if (r_idx == LAST_IDX) begin
              done      <= 1'b1;
              hit_count <= w_cnt_next;
              r_state   <= S_FIN;
            end else begin
              r_idx      <= r_idx + 5'd1;
              read_layer <= r_idx + 5'd1;
              r_state    <= S_ADDR;
            end
          end else if (r_state == S_CHECK) begin
            r_held  <= w_hdr;
            r_state <= S_PUSH;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_header_scanner.sv
// tb/tb_layer_header_scanner.sv - scoreboard bench for layer_header_scanner
module tb_layer_header_scanner;
  localparam int NL = 32;
  localparam int SW = 640;

  logic         clk;
  logic         reset;
  logic         start;
  logic [15:0]  line_y;
  logic [4:0]   read_layer;
  logic [127:0] layer_info;
  logic         busy;
  logic         done;
  logic [5:0]   hit_count;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_layer;
  logic [127:0] out_header;

  layer_header_scanner #(.NUM_LAYERS(NL), .FIFO_DEPTH(4), .SCREEN_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .line_y(line_y),
    .read_layer(read_layer), .layer_info(layer_info),
    .busy(busy), .done(done), .hit_count(hit_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_layer(out_layer), .out_header(out_header)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] hdr [NL];
  always @(posedge clk) layer_info <= hdr[read_layer];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [132:0] exp_q [$];
  int           hit_q [$];
  int           exp_delay = -1;
  int           s_scan = 0;
  int           done_cnt = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input bit en, input int xs, input int ys, input int w, input int h);
    logic [63:0] up;
    up = {$urandom, $urandom};
    return {up, 16'(h), 16'(w), 16'(ys), 16'(xs), 15'($urandom), en};
  endfunction

  // Reference: visibility straight from the header rules, one list per scan
  task automatic model_scan(input logic [15:0] ly, input int delay);
    int n;
    n = 0;
    for (int i = 0; i < NL; i++) begin
      logic [127:0] h;
      int ys, ht, xs, wd;
      bit vis;
      h  = hdr[i];
      xs = int'(h[31:16]);
      ys = int'(h[47:32]);
      wd = int'(h[63:48]);
      ht = int'(h[79:64]);
      vis = h[0] && (int'(ly) >= ys) && (int'(ly) - ys < ht);
`ifdef LAYER_HDR_CLIP_EN
      if (vis && xs >= SW) vis = 0;
      if (vis && wd > SW - xs) h[63:48] = 16'(SW - xs);
`endif
      if (vis) begin
        exp_q.push_back({5'(i), h});
        n++;
      end
    end
    hit_q.push_back(n);
    exp_delay = delay;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual_layer=%0d expected=none", out_layer);
        end else begin
          logic [132:0] e;
          e = exp_q.pop_front();
          chk("out_layer", {123'd0, out_layer}, {123'd0, e[132:128]});
          chk("out_header", out_header, e[127:0]);
        end
      end
      if (done) begin
        done_cnt++;
        if (hit_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected actual=1 expected=0");
        end else begin
          chk("hit_count", {122'd0, hit_count}, 128'(hit_q.pop_front()));
        end
        if (exp_delay >= 0) chk("done_cycle", 128'(cyc - s_scan), 128'(exp_delay));
      end
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return (k >= 20);
    endcase
  endfunction

  task automatic run_scan(input logic [15:0] ly, input int delay, input int mode, input int extra);
    int d0, k, n;
    model_scan(ly, delay);
    d0 = done_cnt;
    start = 1'b1;
    line_y = ly;
    s_scan = cyc;
    out_ready = ready_for(mode, 0);
    tick();
    start = 1'b0;
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      k = cyc - s_scan;
      out_ready = ready_for(mode, k);
      start = (k == extra);
      tick();
      n++;
    end
    start = 1'b0;
    if (n >= 4000) chk("done_timeout", 128'd0, 128'd1);
    chk("idle_after_fin", {127'd0, busy}, 128'd0);
    tick();
    chk("start_in_fin_ignored", {127'd0, busy}, 128'd0);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", {127'd0, out_valid}, 128'd0);
    chk("done_count", 128'(done_cnt), 128'(d0 + 1));
  endtask

  task automatic clear_hdr();
    for (int i = 0; i < NL; i++) hdr[i] = '0;
  endtask

  task automatic rand_hdr(input logic [15:0] ly);
    for (int i = 0; i < NL; i++) begin
      int ys, ht;
      ys = int'(ly) - int'($urandom_range(0, 30)) + int'($urandom_range(0, 5));
      if (ys < 0) ys = 0;
      if (ys > 65535) ys = 65535;
      ht = ($urandom_range(0, 7) == 0) ? 65535 : int'($urandom_range(0, 30));
      hdr[i] = mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 700)), ys, int'($urandom_range(0, 200)), ht);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    line_y = '0;
    out_ready = 1'b1;
    clear_hdr();
    repeat (3) tick();
    chk("rst_read_layer", {123'd0, read_layer}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_hit_count", {122'd0, hit_count}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    reset = 1'b0;
    tick();

    run_scan(16'd10, 2 * NL + 1, 0, -1);

    hdr[3] = mk(1'b1, 12, 5, 30, 10);
    hdr[7] = mk(1'b1, 99, 5, 8, 10);
    run_scan(16'd14, 2 * NL + 1, 0, -1);
    run_scan(16'd15, 2 * NL + 1, 0, -1);

    // 4 pushes fill the FIFO by layer 4's check (cycle 10); ready rises at cycle 20, slot seen at 21
    clear_hdr();
    for (int i = 0; i < 6; i++) hdr[i] = mk(1'b1, i * 10, 100, 50, 20);
    run_scan(16'd110, 2 * NL + 1 + 11, 2, -1);

    clear_hdr();
    hdr[2] = mk(1'b1, 0, 16'hFFF0, 40, 0);
    hdr[4] = mk(1'b1, 0, 16'hFFF0, 40, 16'h20);
    hdr[9] = mk(1'b1, 0, 16'hFFF0, 40, 16'hF);
    run_scan(16'hFFFF, 2 * NL + 1, 0, -1);

    clear_hdr();
    hdr[0] = mk(1'b1, 600, 0, 100, 100);
    hdr[1] = mk(1'b1, 640, 0, 100, 100);
    hdr[2] = mk(1'b1, 10, 0, 100, 100);
    run_scan(16'd50, 2 * NL + 1, 0, -1);

    clear_hdr();
    hdr[3] = mk(1'b1, 12, 5, 30, 10);
    hdr[7] = mk(1'b1, 99, 5, 8, 10);
    run_scan(16'd14, 2 * NL + 1, 0, 20);
    hdr[1] = mk(1'b1, 1, 5, 1, 10);
    run_scan(16'd14, 2 * NL + 1, 0, 2 * NL + 1);

    // Reset in the middle of a scan with entries parked in the FIFO
    hdr[5] = mk(1'b1, 1, 5, 1, 10);
    start = 1'b1;
    line_y = 16'd14;
    out_ready = 1'b0;
    s_scan = cyc;
    exp_delay = -1;
    tick();
    start = 1'b0;
    k = 0;
    while (cyc - s_scan < 30 && k < 100) begin
      tick();
      k++;
    end
    chk("pre_reset_out_valid", {127'd0, out_valid}, 128'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {127'd0, busy}, 128'd0);
    chk("async_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("async_rst_read_layer", {123'd0, read_layer}, 128'd0);
    chk("async_rst_hit_count", {122'd0, hit_count}, 128'd0);
    exp_q.delete();
    hit_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_out_valid", {127'd0, out_valid}, 128'd0);
    run_scan(16'd14, 2 * NL + 1, 0, -1);

    for (int r = 0; r < 12; r++) begin
      logic [15:0] ly;
      ly = 16'($urandom_range(0, 65535));
      rand_hdr(ly);
      if (r % 2 == 0) run_scan(ly, 2 * NL + 1, 0, -1);
      else run_scan(ly, -1, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
